mmio_timer: RTL and testbench

Memory-mapped 64-bit timer/compare peripheral that responds to the CPU data-memory interface (address, size, write enable, write data out; read data back). It sits beside data RAM on the CPU memory bus, decodes a fixed 64-byte address window, serves single-cycle combinational reads and clocked writes, and raises an interrupt request when the free-running counter reaches a programmed compare value.

---
 rtl/mmio_timer_if.sv | 35 +++
 rtl/mmio_timer.sv | 199 +++++++++++++++++++
 tb/tb_mmio_timer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_timer_if.sv
// mmio_timer_if
// CPU data-memory bus bundle as seen by a memory-mapped peripheral.
//   memory_address          byte address from the CPU
//   memory_read_write_size  00 byte, 01 half, 10/11 word
//   memory_write_enable     write strobe, sampled on the rising clock edge
//   memory_write_value      write data, byte/half data in the low bits
//   memory_read_value       combinational read data from the peripheral
//   selected                peripheral claims the address (bus mux select)
// The master modport is the CPU side, the slave modport the peripheral side.
interface mmio_timer_if;
  logic [31:0] memory_address;
  logic [1:0]  memory_read_write_size;
  logic        memory_write_enable;
  logic [31:0] memory_write_value;
  logic [31:0] memory_read_value;
  logic        selected;

  modport master (
    output memory_address,
    output memory_read_write_size,
    output memory_write_enable,
    output memory_write_value,
    input  memory_read_value,
    input  selected
  );

  modport slave (
    input  memory_address,
    input  memory_read_write_size,
    input  memory_write_enable,
    input  memory_write_value,
    output memory_read_value,
    output selected
  );
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer
// Memory-mapped 64-bit timer with compare interrupt. Decodes a 64-byte
// window at BASE_ADDRESS, serves combinational reads and clocked writes.
//   clock    single clock, all state updates on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      CPU data-memory bus (slave side), see mmio_timer_if
//   irq      timer interrupt request, registered
// Register map (offset = address[5:0]):
//   0x00/0x04 MTIME lo/hi, 0x08/0x0C CMP lo/hi,
//   0x10 CTRL {prescale[15:8], irq_enable[1], enable[0]},
//   0x14 STATUS {pending[0]} write-1-to-clear, 0x18..0x3C read as zero.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_F000
) (
  input  logic          clock,
  input  logic          reset_n,
  mmio_timer_if.slave   bus,
  output logic          irq
);

  logic [63:0] mtime;
  logic [63:0] cmp;
  logic        ctrl_enable;
  logic        ctrl_irq_enable;
  logic [7:0]  prescale;
  logic [7:0]  pre_cnt;
  logic        pending;

  logic [63:0] mtime_next;
  logic [63:0] cmp_next;
  logic        ctrl_enable_next;
  logic        ctrl_irq_enable_next;
  logic [7:0]  prescale_next;
  logic [7:0]  pre_cnt_next;
  logic        pending_next;

  logic        in_window;
  logic        aligned;
  logic        access_ok;
  logic [3:0]  reg_index;
  logic [1:0]  lane;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic [31:0] ctrl_word;
  logic [31:0] reg_word;
  logic [31:0] shifted_word;
  logic        write_active;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_ctrl;
  logic        wr_status;
  logic        status_clear;
  logic        compare_hit;

  // Replace only the byte lanes selected by mask, keep the rest.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_value,
                                              input logic [31:0] new_value,
                                              input logic [3:0]  mask);
    logic [31:0] result;
    result = old_value;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) result[8*i +: 8] = new_value[8*i +: 8];
    end
    return result;
  endfunction

  // Address decode: window match, register index, lane mask and alignment.
  always_comb begin
    in_window = (bus.memory_address[31:6] == BASE_ADDRESS[31:6]);
    reg_index = bus.memory_address[5:2];
    lane      = bus.memory_address[1:0];
    aligned   = 1'b1;
    lane_mask = 4'b1111;
    case (bus.memory_read_write_size)
      2'b00: begin
        aligned   = 1'b1;
        lane_mask = 4'b0001 << lane;
      end
      2'b01: begin
        aligned   = ~lane[0];
        lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        aligned   = (lane == 2'b00);
        lane_mask = 4'b1111;
      end
    endcase
    access_ok = in_window & aligned;
  end

  assign bus.selected = in_window;

  assign ctrl_word = {16'h0000, prescale, 6'b000000, ctrl_irq_enable, ctrl_enable};

  // Read path: pick the register word, move the addressed lane down to bit 0
  // and zero everything above the access size.
  always_comb begin
    case (reg_index)
      4'd0:    reg_word = mtime[31:0];
      4'd1:    reg_word = mtime[63:32];
      4'd2:    reg_word = cmp[31:0];
      4'd3:    reg_word = cmp[63:32];
      4'd4:    reg_word = ctrl_word;
      4'd5:    reg_word = {31'h0, pending};
      default: reg_word = 32'h0;
    endcase
    shifted_word = reg_word >> {lane, 3'b000};
    if (!access_ok) begin
      bus.memory_read_value = 32'h0;
    end else begin
      case (bus.memory_read_write_size)
        2'b00:   bus.memory_read_value = {24'h0, shifted_word[7:0]};
        2'b01:   bus.memory_read_value = {16'h0, shifted_word[15:0]};
        default: bus.memory_read_value = shifted_word;
      endcase
    end
  end

  // Write decode: low-aligned write data is moved up to the addressed lanes.
  always_comb begin
    lane_data    = bus.memory_write_value << {lane, 3'b000};
    write_active = bus.memory_write_enable & access_ok;
    wr_mtime_lo  = write_active & (reg_index == 4'd0);
    wr_mtime_hi  = write_active & (reg_index == 4'd1);
    wr_cmp_lo    = write_active & (reg_index == 4'd2);
    wr_cmp_hi    = write_active & (reg_index == 4'd3);
    wr_ctrl      = write_active & (reg_index == 4'd4);
    wr_status    = write_active & (reg_index == 4'd5);
    status_clear = wr_status & lane_mask[0] & lane_data[0];
  end

  // Counter and prescaler. A software write to either MTIME half takes
  // priority over counting for that cycle and restarts the prescaler, so the
  // next increment comes a full prescale period after the write.
  always_comb begin
    mtime_next   = mtime;
    pre_cnt_next = pre_cnt;
    if (wr_mtime_lo | wr_mtime_hi) begin
      if (wr_mtime_lo) mtime_next[31:0]  = merge_lanes(mtime[31:0], lane_data, lane_mask);
      if (wr_mtime_hi) mtime_next[63:32] = merge_lanes(mtime[63:32], lane_data, lane_mask);
      pre_cnt_next = 8'h00;
    end else if (ctrl_enable) begin
      if (pre_cnt == prescale) begin
        pre_cnt_next = 8'h00;
        mtime_next   = mtime + 64'd1;
      end else begin
        pre_cnt_next = pre_cnt + 8'd1;
      end
    end else begin
      pre_cnt_next = 8'h00;
    end
  end

  // Compare, control and status. The compare uses the registered values, so
  // pending rises one edge after MTIME reaches CMP, and a simultaneous
  // software clear loses against a live compare hit.
  always_comb begin
    cmp_next             = cmp;
    ctrl_enable_next     = ctrl_enable;
    ctrl_irq_enable_next = ctrl_irq_enable;
    prescale_next        = prescale;
    if (wr_cmp_lo) cmp_next[31:0]  = merge_lanes(cmp[31:0], lane_data, lane_mask);
    if (wr_cmp_hi) cmp_next[63:32] = merge_lanes(cmp[63:32], lane_data, lane_mask);
    if (wr_ctrl && lane_mask[0]) begin
      ctrl_enable_next     = lane_data[0];
      ctrl_irq_enable_next = lane_data[1];
    end
    if (wr_ctrl && lane_mask[1]) prescale_next = lane_data[15:8];
    compare_hit  = (mtime >= cmp);
    pending_next = compare_hit | (pending & ~status_clear);
  end

  // State registers. irq is registered from the next-state values so it is
  // a clean flop output that tracks pending & irq_enable without glitches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mtime           <= 64'h0;
      cmp             <= 64'hFFFF_FFFF_FFFF_FFFF;
      ctrl_enable     <= 1'b0;
      ctrl_irq_enable <= 1'b0;
      prescale        <= 8'h00;
      pre_cnt         <= 8'h00;
      pending         <= 1'b0;
      irq             <= 1'b0;
    end else begin
      mtime           <= mtime_next;
      cmp             <= cmp_next;
      ctrl_enable     <= ctrl_enable_next;
      ctrl_irq_enable <= ctrl_irq_enable_next;
      prescale        <= prescale_next;
      pre_cnt         <= pre_cnt_next;
      pending         <= pending_next;
      irq             <= pending_next & ctrl_irq_enable_next;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer
// Testbench for mmio_timer. A byte-oriented model of the register window
// tracks the peripheral state; a compare process checks read data, select
// and irq against it on every falling edge, and directed sequences add
// hand-computed literal expectations.
module tb_mmio_timer;
  localparam logic [31:0] BASE = 32'h0000_F000;

  logic clock;
  logic reset_n;
  logic irq;

  mmio_timer_if bus ();

  mmio_timer #(.BASE_ADDRESS(BASE)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .irq     (irq)
  );

  int vectors;
  int miscompares;

  typedef struct packed {
    logic [63:0] mtime;
    logic [63:0] cmp;
    logic        en;
    logic        ie;
    logic [7:0]  p;
    logic [7:0]  pre;
    logic        pend;
  } model_t;

  model_t m;

  // Clock generation
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic model_t model_reset();
    model_t r;
    r.mtime = 64'h0;
    r.cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    r.en    = 1'b0;
    r.ie    = 1'b0;
    r.p     = 8'h00;
    r.pre   = 8'h00;
    r.pend  = 1'b0;
    return r;
  endfunction

  function automatic bit model_in_window(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'h3F);
  endfunction

  function automatic int model_size_bytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit model_ok(input logic [31:0] a, input logic [1:0] sz);
    int n;
    n = model_size_bytes(sz);
    return model_in_window(a) && ((int'(a[5:0]) % n) == 0);
  endfunction

  // Byte at window offset off, as software would see it.
  function automatic logic [7:0] model_byte(input model_t s, input int off);
    if (off < 8)   return s.mtime[8*off +: 8];
    if (off < 16)  return s.cmp[8*(off-8) +: 8];
    if (off == 16) return {6'b0, s.ie, s.en};
    if (off == 17) return s.p;
    if (off == 20) return {7'b0, s.pend};
    return 8'h00;
  endfunction

  function automatic logic [31:0] model_read(input model_t s, input logic [31:0] a,
                                             input logic [1:0] sz);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = model_size_bytes(sz);
    if (model_ok(a, sz)) begin
      for (int j = 0; j < n; j++) v[8*j +: 8] = model_byte(s, int'(a[5:0]) + j);
    end
    return v;
  endfunction

  function automatic model_t model_step(input model_t s, input logic [31:0] a,
                                        input logic [1:0] sz, input logic we,
                                        input logic [31:0] d);
    model_t n;
    bit hit;
    bit clr;
    bit mt_written;
    int nb;
    int off;
    logic [7:0] b;
    n = s;
    hit = (s.mtime >= s.cmp);
    clr = 1'b0;
    mt_written = 1'b0;
    nb = model_size_bytes(sz);
    if (we && model_ok(a, sz)) begin
      for (int j = 0; j < nb; j++) begin
        b = d[8*j +: 8];
        off = int'(a[5:0]) + j;
        if (off < 8) begin
          n.mtime[8*off +: 8] = b;
          mt_written = 1'b1;
        end else if (off < 16) begin
          n.cmp[8*(off-8) +: 8] = b;
        end else if (off == 16) begin
          n.en = b[0];
          n.ie = b[1];
        end else if (off == 17) begin
          n.p = b;
        end else if (off == 20) begin
          clr = b[0];
        end
      end
    end
    if (mt_written) begin
      n.pre = 8'h00;
    end else if (s.en) begin
      if (s.pre == s.p) begin
        n.pre = 8'h00;
        n.mtime = s.mtime + 64'd1;
      end else begin
        n.pre = s.pre + 8'd1;
      end
    end else begin
      n.pre = 8'h00;
    end
    n.pend = hit | (s.pend & ~clr);
    return n;
  endfunction

  // Model state follows the same clock and asynchronous reset as the DUT.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m <= model_reset();
    else m <= model_step(m, bus.memory_address, bus.memory_read_write_size,
                         bus.memory_write_enable, bus.memory_write_value);
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    check_output("model_rdata", bus.memory_read_value,
                 model_read(m, bus.memory_address, bus.memory_read_write_size));
    check_output("model_selected", {31'h0, bus.selected},
                 {31'h0, model_in_window(bus.memory_address)});
    check_output("model_irq", {31'h0, irq}, {31'h0, m.pend & m.ie});
  end

  // Each stimulus task starts and ends 1ns after a rising edge.
  task automatic bus_idle();
    bus.memory_address         = 32'h0;
    bus.memory_read_write_size = 2'b10;
    bus.memory_write_enable    = 1'b0;
    bus.memory_write_value     = 32'h0;
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic [1:0] sz,
                                input logic [31:0] d);
    bus.memory_address         = a;
    bus.memory_read_write_size = sz;
    bus.memory_write_enable    = 1'b1;
    bus.memory_write_value     = d;
    @(posedge clock);
    #1;
    bus_idle();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic read_expect(input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] expected, input logic exp_sel,
                             input string name);
    bus.memory_address         = a;
    bus.memory_read_write_size = sz;
    bus.memory_write_enable    = 1'b0;
    @(negedge clock);
    check_output(name, bus.memory_read_value, expected);
    check_output({name, "_sel"}, {31'h0, bus.selected}, {31'h0, exp_sel});
    @(posedge clock);
    #1;
    bus_idle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    bus_idle();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Reset values
    read_expect(BASE + 32'h00, 2'b10, 32'h0000_0000, 1'b1, "rst_mtime_lo");
    read_expect(BASE + 32'h04, 2'b10, 32'h0000_0000, 1'b1, "rst_mtime_hi");
    read_expect(BASE + 32'h08, 2'b10, 32'hFFFF_FFFF, 1'b1, "rst_cmp_lo");
    read_expect(BASE + 32'h0C, 2'b10, 32'hFFFF_FFFF, 1'b1, "rst_cmp_hi");
    read_expect(BASE + 32'h10, 2'b10, 32'h0000_0000, 1'b1, "rst_ctrl");
    read_expect(BASE + 32'h14, 2'b10, 32'h0000_0000, 1'b1, "rst_status");

    // Count with P=3: one increment every 4 edges, 10 after 40 edges
    apply_stimulus(BASE + 32'h10, 2'b10, 32'h0000_0301);
    idle_cycles(40);
    read_expect(BASE + 32'h00, 2'b10, 32'd10, 1'b1, "count_40");
    apply_stimulus(BASE + 32'h10, 2'b10, 32'h0000_0000);
    read_expect(BASE + 32'h00, 2'b10, 32'd10, 1'b1, "count_hold");

    // MTIME write while running restarts the prescaler (P=2)
    apply_stimulus(BASE + 32'h10, 2'b10, 32'h0000_0201);
    idle_cycles(5);
    apply_stimulus(BASE + 32'h00, 2'b10, 32'h0000_0100);
    idle_cycles(7);
    apply_stimulus(BASE + 32'h10, 2'b10, 32'h0000_0000);
    read_expect(BASE + 32'h00, 2'b10, 32'h0000_0102, 1'b1, "prescale_reload");

    // Asynchronous reset in the middle of a count with irq active
    apply_stimulus(BASE + 32'h10, 2'b10, 32'h0000_0003);
    apply_stimulus(BASE + 32'h08, 2'b10, 32'h0000_0000);
    apply_stimulus(BASE + 32'h0C, 2'b10, 32'h0000_0000);
    idle_cycles(3);
    check_output("pre_rst_irq", {31'h0, irq}, 32'h1);
    bus.memory_address = BASE + 32'h00;
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_rst_mtime", bus.memory_read_value, 32'h0);
    check_output("async_rst_irq", {31'h0, irq}, 32'h0);
    bus.memory_address = BASE + 32'h08;
    #1;
    check_output("async_rst_cmp", bus.memory_read_value, 32'hFFFF_FFFF);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    bus_idle();
    idle_cycles(1);

    // 64-bit wrap
    apply_stimulus(BASE + 32'h04, 2'b10, 32'hFFFF_FFFF);
    apply_stimulus(BASE + 32'h00, 2'b10, 32'hFFFF_FFFF);
    apply_stimulus(BASE + 32'h10, 2'b10, 32'h0000_0001);
    read_expect(BASE + 32'h00, 2'b10, 32'hFFFF_FFFF, 1'b1, "wrap_before");
    read_expect(BASE + 32'h04, 2'b10, 32'h0000_0000, 1'b1, "wrap_hi");
    read_expect(BASE + 32'h00, 2'b10, 32'h0000_0001, 1'b1, "wrap_lo_after");
    apply_stimulus(BASE + 32'h10, 2'b10, 32'h0000_0000);
    apply_stimulus(BASE + 32'h14, 2'b10, 32'h0000_0001);

    // Compare interrupt
    apply_stimulus(BASE + 32'h00, 2'b10, 32'h0000_0000);
    apply_stimulus(BASE + 32'h04, 2'b10, 32'h0000_0000);
    apply_stimulus(BASE + 32'h08, 2'b10, 32'h0000_0005);
    apply_stimulus(BASE + 32'h0C, 2'b10, 32'h0000_0000);
    read_expect(BASE + 32'h14, 2'b10, 32'h0, 1'b1, "int_idle");
    apply_stimulus(BASE + 32'h10, 2'b10, 32'h0000_0003);
    idle_cycles(5);
    read_expect(BASE + 32'h14, 2'b10, 32'h0, 1'b1, "int_not_yet");
    read_expect(BASE + 32'h14, 2'b10, 32'h1, 1'b1, "int_pending");
    check_output("int_irq", {31'h0, irq}, 32'h1);
    apply_stimulus(BASE + 32'h14, 2'b10, 32'h0000_0001);
    read_expect(BASE + 32'h14, 2'b10, 32'h1, 1'b1, "int_sticky");
    apply_stimulus(BASE + 32'h0C, 2'b10, 32'hFFFF_FFFF);
    apply_stimulus(BASE + 32'h14, 2'b10, 32'h0000_0001);
    read_expect(BASE + 32'h14, 2'b10, 32'h0, 1'b1, "int_cleared");
    check_output("int_irq_low", {31'h0, irq}, 32'h0);

    // Pending without irq_enable keeps irq low
    apply_stimulus(BASE + 32'h10, 2'b10, 32'h0000_0001);
    apply_stimulus(BASE + 32'h0C, 2'b10, 32'h0000_0000);
    idle_cycles(2);
    read_expect(BASE + 32'h14, 2'b10, 32'h1, 1'b1, "noie_pending");
    check_output("noie_irq", {31'h0, irq}, 32'h0);
    apply_stimulus(BASE + 32'h10, 2'b10, 32'h0000_0000);
    apply_stimulus(BASE + 32'h0C, 2'b10, 32'hFFFF_FFFF);
    apply_stimulus(BASE + 32'h14, 2'b10, 32'h0000_0001);

    // Sub-word accesses
    apply_stimulus(BASE + 32'h08, 2'b10, 32'hFFFF_FFFF);
    apply_stimulus(BASE + 32'h0A, 2'b00, 32'h1234_56AB);
    read_expect(BASE + 32'h08, 2'b10, 32'hFFAB_FFFF, 1'b1, "byte_wr");
    read_expect(BASE + 32'h0B, 2'b01, 32'h0000_0000, 1'b1, "half_misaligned_rd");
    read_expect(BASE + 32'h0A, 2'b00, 32'h0000_00AB, 1'b1, "byte_rd");
    read_expect(BASE + 32'h0A, 2'b01, 32'h0000_FFAB, 1'b1, "half_rd");
    read_expect(BASE + 32'h09, 2'b10, 32'h0000_0000, 1'b1, "word_misaligned_rd");
    apply_stimulus(BASE + 32'h09, 2'b01, 32'h0000_5555);
    apply_stimulus(BASE + 32'h09, 2'b10, 32'h5555_5555);
    apply_stimulus(BASE + 32'h0A, 2'b01, 32'hDEAD_1234);
    read_expect(BASE + 32'h08, 2'b10, 32'h1234_FFFF, 1'b1, "half_wr");

    // Decode and ignored locations
    read_expect(BASE + 32'h40, 2'b10, 32'h0, 1'b0, "out_of_window");
    read_expect(BASE + 32'h18, 2'b10, 32'h0, 1'b1, "reserved_rd");
    apply_stimulus(BASE + 32'h48, 2'b10, 32'h5555_5555);
    apply_stimulus(BASE + 32'h18, 2'b10, 32'h7777_7777);
    apply_stimulus(BASE + 32'h3C, 2'b10, 32'h0000_0001);
    read_expect(BASE + 32'h08, 2'b10, 32'h1234_FFFF, 1'b1, "decode_wr_ignored");
    read_expect(BASE + 32'h18, 2'b10, 32'h0, 1'b1, "reserved_after_wr");

    // CTRL keeps only its defined bits
    apply_stimulus(BASE + 32'h10, 2'b10, 32'hFFFF_FFFC);
    read_expect(BASE + 32'h10, 2'b10, 32'h0000_FF00, 1'b1, "ctrl_mask");
    read_expect(BASE + 32'h11, 2'b00, 32'h0000_00FF, 1'b1, "ctrl_byte1");
    apply_stimulus(BASE + 32'h10, 2'b10, 32'h0000_0000);
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
